// File: rtl/switch_bank_ctrl.sv
// switch_bank_ctrl
// ----------------
// Slide-switch peripheral on the 8-bit CPU data bus. Each switch is
// synchronised, debounced against a shared millisecond-style tick, and
// edge-detected into a sticky FLAG bit. A per-switch MASK bit decides
// whether an edge also raises SEND_INTERRUPT, which is held until the
// interrupt controller answers with a one-cycle INTERRUPT_ACK.
//
// Register map (NB = N_SW/8, byte k holds switches [8k+7:8k]):
//   BASE+k       STATE  read-only debounced levels
//   BASE+NB+k    FLAG   read, write-1-to-clear
//   BASE+2NB+k   MASK   read/write interrupt enable, reset 0xFF
//   BASE+3NB     CTRL   bit0 rising-edge enable, bit1 falling-edge enable,
//                       bits[7:2] read 0, reset 0x03
//
// Bus handshake: a register is written on the CLK edge where BUS_WE=1 and
// BUS_ADDR falls inside the map. A read is BUS_WE=0 with a mapped address;
// the read enable and read data are registered on that edge and BUS_DATA is
// driven from then until the first edge at which the address stops
// matching. Reads have no side effects; unmapped addresses leave BUS_DATA Z.
//
// Ports:
//   CLK            system clock
//   RESETN         asynchronous active-low reset
//   SW             raw switch levels, asynchronous to CLK
//   BUS_DATA       shared bidirectional data bus
//   BUS_ADDR       bus address
//   BUS_WE         1 = write, 0 = read
//   SEND_INTERRUPT interrupt request level
//   INTERRUPT_ACK  one-cycle acknowledge from the interrupt controller

module switch_bank_ctrl #(
    parameter int         N_SW        = 16,
    parameter logic [7:0] BASE_ADDR   = 8'hE0,
    parameter int         TICK_CYCLES = 50000,
    parameter int         DEB_TICKS   = 4
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [N_SW-1:0] SW,
    inout  wire  [7:0]      BUS_DATA,
    input  logic [7:0]      BUS_ADDR,
    input  logic            BUS_WE,
    output logic            SEND_INTERRUPT,
    input  logic            INTERRUPT_ACK
);

    localparam int NB     = N_SW / 8;
    localparam int N_REGS = 3 * NB + 1;
    localparam int TW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW     = $clog2(DEB_TICKS) + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_SW-1:0]          sync1_q, sync1_d;
    logic [N_SW-1:0]          sync2_q, sync2_d;
    logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
    logic [N_SW-1:0][CW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [N_SW-1:0]          state_q, state_d;
    // One-cycle-delayed copy of the debounced levels; comparing the two
    // gives edges one cycle after the STATE flip.
    logic [N_SW-1:0]          state_dly_q, state_dly_d;
    logic [N_SW-1:0]          flag_q, flag_d;
    logic [N_SW-1:0]          mask_q, mask_d;
    logic [1:0]               ctrl_q, ctrl_d;
    logic                     irq_q, irq_d;
    logic                     rd_en_q, rd_en_d;
    logic [7:0]               rd_data_q, rd_data_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // A 9-bit difference keeps the borrow so addresses below BASE_ADDR
    // never alias into the map.
    logic [8:0] addr_diff;
    logic [7:0] addr_off;
    logic       addr_hit;
    logic       wr_en;
    int         off_i;

    assign addr_diff = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
    assign addr_off  = addr_diff[7:0];
    assign addr_hit  = !addr_diff[8] && (addr_off < 8'(N_REGS));
    assign wr_en     = addr_hit && BUS_WE;
    assign off_i     = 32'(addr_off);

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // ------------------------------------------------------------------
    // Synchroniser and per-bit debounce
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d   = SW;
        sync2_d   = sync1_q;
        deb_cnt_d = deb_cnt_q;
        state_d   = state_q;
        for (int i = 0; i < N_SW; i++) begin
            if (sync2_q[i] == state_q[i]) begin
                // Any cycle of agreement discards accumulated progress, so
                // a glitch never leaves a partially counted change behind.
                deb_cnt_d[i] = '0;
            end else if (tick) begin
                if (deb_cnt_q[i] + CW'(1) == DEB_LAST) begin
                    state_d[i]   = ~state_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection, flags, interrupt
    // ------------------------------------------------------------------
    logic [N_SW-1:0] rise_ev;
    logic [N_SW-1:0] fall_ev;
    logic [N_SW-1:0] edge_ev;
    logic [N_SW-1:0] w1c;

    assign rise_ev = state_q & ~state_dly_q & {N_SW{ctrl_q[0]}};
    assign fall_ev = ~state_q & state_dly_q & {N_SW{ctrl_q[1]}};
    assign edge_ev = rise_ev | fall_ev;

    always_comb begin
        state_dly_d = state_q;
        mask_d      = mask_q;
        ctrl_d      = ctrl_q;
        w1c         = '0;
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (off_i == NB + k) begin
                    w1c[8*k +: 8] = BUS_DATA;
                end
                if (off_i == 2 * NB + k) begin
                    mask_d[8*k +: 8] = BUS_DATA;
                end
            end
            if (off_i == 3 * NB) begin
                ctrl_d = BUS_DATA[1:0];
            end
        end
        // OR-ing the new events after the clear makes a coincident event
        // win over software's write-1-to-clear.
        flag_d = (flag_q & ~w1c) | edge_ev;
        // Likewise a new masked-in event wins over a same-cycle ACK.
        // Pending is tracked separately from FLAG contents.
        irq_d  = (irq_q & ~INTERRUPT_ACK) | (|(edge_ev & mask_q));
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NB; k++) begin
            if (off_i == k) begin
                rd_mux = state_q[8*k +: 8];
            end
            if (off_i == NB + k) begin
                rd_mux = flag_q[8*k +: 8];
            end
            if (off_i == 2 * NB + k) begin
                rd_mux = mask_q[8*k +: 8];
            end
        end
        if (off_i == 3 * NB) begin
            rd_mux = {6'b0, ctrl_q};
        end
        rd_en_d   = addr_hit && !BUS_WE;
        rd_data_d = rd_mux;
    end

    assign BUS_DATA       = rd_en_q ? rd_data_q : 8'bz;
    assign SEND_INTERRUPT = irq_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tick_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            state_q     <= '0;
            state_dly_q <= '0;
            flag_q      <= '0;
            mask_q      <= '1;
            ctrl_q      <= 2'b11;
            irq_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_cnt_q  <= tick_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            state_dly_q <= state_dly_d;
            flag_q      <= flag_d;
            mask_q      <= mask_d;
            ctrl_q      <= ctrl_d;
            irq_q       <= irq_d;
            rd_en_q     <= rd_en_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_switch_bank_ctrl.sv
// Directed bench for switch_bank_ctrl with N_SW=16, BASE_ADDR=E0,
// TICK_CYCLES=10, DEB_TICKS=3. Inputs change on the falling edge and
// outputs are sampled on the falling edge. A pull-up on the bus makes an
// undriven BUS_DATA read back as 8'hFF.

module tb_switch_bank_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] sw = '0;
    wire  [7:0]  bus_data;
    logic [7:0]  bus_addr = 8'h00;
    logic        bus_we = 1'b0;
    logic        send_interrupt;
    logic        interrupt_ack = 1'b0;
    logic [7:0]  tb_drv = 8'h00;
    logic        tb_oe = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign bus_data = tb_oe ? tb_drv : 8'bz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    switch_bank_ctrl #(
        .N_SW        (16),
        .BASE_ADDR   (8'hE0),
        .TICK_CYCLES (10),
        .DEB_TICKS   (3)
    ) dut (
        .CLK            (clk),
        .RESETN         (resetn),
        .SW             (sw),
        .BUS_DATA       (bus_data),
        .BUS_ADDR       (bus_addr),
        .BUS_WE         (bus_we),
        .SEND_INTERRUPT (send_interrupt),
        .INTERRUPT_ACK  (interrupt_ack)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {7'd0, send_interrupt}, {7'd0, exp});
    endtask

    // ---------------- driver tasks (called on a falling edge) ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One idle cycle first so a preceding read has released the bus.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_we   = 1'b1;
        tb_drv   = d;
        tb_oe    = 1'b1;
        @(negedge clk);
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b0;
        @(negedge clk);
        d = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;

        repeat (5) @(negedge clk);
        check_irq("reset_irq_low", 1'b0);
        resetn = 1'b1;
        read_check("reset_state0", 8'hE0, 8'h00);
        read_check("reset_state1", 8'hE1, 8'h00);
        read_check("reset_flag0",  8'hE2, 8'h00);
        read_check("reset_mask0",  8'hE4, 8'hFF);
        read_check("reset_mask1",  8'hE5, 8'hFF);
        read_check("reset_ctrl",   8'hE6, 8'h03);

        // Steady SW[0] high: accepted within 33 cycles.
        sw = 16'h0001;
        wait_cycles(33);
        read_check("sw0_state0", 8'hE0, 8'h01);
        read_check("sw0_state1", 8'hE1, 8'h00);
        read_check("sw0_flag0",  8'hE2, 8'h01);
        check_irq("sw0_irq_set", 1'b1);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        check_irq("sw0_irq_after_ack", 1'b0);
        bus_write(8'hE2, 8'h01);
        read_check("sw0_flag_w1c", 8'hE2, 8'h00);
        bus_write(8'hE0, 8'hFF);
        read_check("state_write_ignored", 8'hE0, 8'h01);

        // 15-cycle glitch on SW[3] is shorter than three ticks.
        sw[3] = 1'b1;
        wait_cycles(15);
        sw[3] = 1'b0;
        wait_cycles(40);
        read_check("glitch_state0", 8'hE0, 8'h01);
        read_check("glitch_flag0",  8'hE2, 8'h00);
        check_irq("glitch_irq", 1'b0);

        // Falling-edge only.
        bus_write(8'hE6, 8'h02);
        read_check("ctrl_readback", 8'hE6, 8'h02);
        sw[9] = 1'b1;
        wait_cycles(40);
        read_check("fall_only_state1", 8'hE1, 8'h02);
        read_check("fall_only_no_rise_flag", 8'hE3, 8'h00);
        check_irq("fall_only_no_rise_irq", 1'b0);
        sw[9] = 1'b0;
        wait_cycles(40);
        read_check("fall_only_flag1", 8'hE3, 8'h02);
        check_irq("fall_only_irq", 1'b1);
        pulse_ack();
        bus_write(8'hE3, 8'h02);
        read_check("fall_only_flag1_clr", 8'hE3, 8'h00);

        // Masked-out switches flag but do not interrupt.
        bus_write(8'hE6, 8'h03);
        bus_write(8'hE4, 8'h00);
        bus_write(8'hE5, 8'h00);
        read_check("mask0_readback", 8'hE4, 8'h00);
        sw[0] = 1'b0;
        wait_cycles(40);
        read_check("masked_fall_flag0", 8'hE2, 8'h01);
        check_irq("masked_fall_irq", 1'b0);
        bus_write(8'hE2, 8'h01);
        sw[0] = 1'b1;
        wait_cycles(40);
        read_check("masked_rise_state0", 8'hE0, 8'h01);
        read_check("masked_rise_flag0", 8'hE2, 8'h01);
        check_irq("masked_rise_irq", 1'b0);

        // ACK held through the cycle a masked-in event arrives.
        bus_write(8'hE4, 8'hFF);
        bus_write(8'hE5, 8'hFF);
        bus_write(8'hE2, 8'hFF);
        interrupt_ack = 1'b1;
        sw[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (send_interrupt) found = 1'b1;
        end
        interrupt_ack = 1'b0;
        check("ack_coincident_set_seen", {7'd0, found}, 8'd1);
        @(negedge clk);
        check_irq("ack_coincident_irq_held", 1'b1);
        pulse_ack();
        check_irq("ack_coincident_cleared", 1'b0);
        bus_write(8'hE2, 8'hFF);
        read_check("flags_cleared", 8'hE2, 8'h00);

        // W1C on bit 2 held continuously while SW[2] rises.
        @(negedge clk);
        bus_addr = 8'hE2;
        bus_we   = 1'b1;
        tb_drv   = 8'h04;
        tb_oe    = 1'b1;
        sw[2]    = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (send_interrupt) found = 1'b1;
        end
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        bus_addr = 8'h00;
        check("w1c_coincident_event_seen", {7'd0, found}, 8'd1);
        read_check("w1c_coincident_flag0", 8'hE2, 8'h04);

        // Reset mid-debounce with all switches high and non-default regs.
        bus_write(8'hE5, 8'h0F);
        bus_write(8'hE6, 8'h01);
        sw = 16'hFFFF;
        wait_cycles(15);
        resetn = 1'b0;
        @(negedge clk);
        check_irq("midreset_irq", 1'b0);
        wait_cycles(2);
        resetn = 1'b1;
        read_check("postreset_state0", 8'hE0, 8'h00);
        read_check("postreset_state1", 8'hE1, 8'h00);
        read_check("postreset_flag0",  8'hE2, 8'h00);
        read_check("postreset_flag1",  8'hE3, 8'h00);
        read_check("postreset_mask1",  8'hE5, 8'hFF);
        read_check("postreset_ctrl",   8'hE6, 8'h03);
        check_irq("postreset_irq", 1'b0);
        wait_cycles(40);
        read_check("redeb_state0", 8'hE0, 8'hFF);
        read_check("redeb_state1", 8'hE1, 8'hFF);
        read_check("redeb_flag0",  8'hE2, 8'hFF);
        read_check("redeb_flag1",  8'hE3, 8'hFF);
        check_irq("redeb_irq", 1'b1);

        // Unmapped addresses just past and just before the map.
        read_check("unmapped_e7_z", 8'hE7, 8'hFF);
        read_check("unmapped_df_z", 8'hDF, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/switch_bank_ctrl.md
# switch_bank_ctrl

Parametrised slide-switch peripheral on the 8-bit CPU data bus, successor to the fixed 16-switch block. It synchronises and debounces each switch separately, and latches per-switch change flags with selectable rising/falling edge detection. Each switch has its own interrupt-enable bit, and the block raises SEND_INTERRUPT using the standard ACK handshake. It sits on the peripheral bus at BASE_ADDR and occupies 3·NB+1 byte addresses, where NB = N_SW/8.

## Interface
- N_SW, 16: number of switches; multiple of 8, range 8..32.
- BASE_ADDR, 8'hE0: first bus address.
- TICK_CYCLES, 50000: CLK cycles per debounce tick (1 ms at 50 MHz); ≥2.
- DEB_TICKS, 4: consecutive ticks a new level must persist before it is accepted; ≥1.
- CLK  in  1  system clock, 50 MHz.
- RESETN  in  1  asynchronous, active-low reset.
- SW  in  N_SW  raw switch levels, asynchronous to CLK.
- BUS_DATA  inout  8  shared data bus; driven only during a read of this block, Z otherwise.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = write, 0 = read.
- SEND_INTERRUPT  out  1  interrupt request level; reset 0.
- INTERRUPT_ACK  in  1  one-cycle acknowledge from the interrupt controller.

## Operation
- Register map, k = 0..NB-1; byte k holds bits [8k+7:8k]:
  - BASE+k: STATE, read-only, debounced switch levels.
  - BASE+NB+k: FLAG, read; write 1 clears the bit (W1C).
  - BASE+2NB+k: MASK, R/W, interrupt enable per switch; reset 0xFF.
  - BASE+3NB: CTRL, R/W.
    - bit0 = rising-edge enable; bit1 = falling-edge enable; bits[7:2] read 0.
    - reset 0x03.
- Unmapped addresses are never driven. Writes to STATE are ignored.
- Synchroniser: 2-flop chain per bit on every CLK, reset 0.
- Tick generator: one free-running counter, 0..TICK_CYCLES-1. A tick pulse is high for one cycle at the terminal count.
- Per-bit debounce counter, width clog2(DEB_TICKS)+1:
  - sync bit == debounced bit: counter cleared to 0, every cycle.
  - sync bit != debounced bit, on a tick: counter increments.
  - counter reaches DEB_TICKS on a tick: debounced bit flips and the counter clears.
  - A glitch shorter than the accumulated ticks resets progress; no partial acceptance.
- Edge event on a bit: the debounced bit flips 0→1 with CTRL.bit0=1, or 1→0 with CTRL.bit1=1.
- Edge event sets the bit's FLAG, whether or not MASK is set.
- Same-cycle FLAG set and W1C on the same bit: set wins.
- Interrupt pending:
  - set when any edge event occurs on a bit whose MASK=1;
  - cleared by INTERRUPT_ACK;
  - set and ACK in the same cycle: stays set;
  - independent of FLAG contents, so software must clear FLAG itself.
- Reset mid-operation returns all state to reset values. STATE reads 0 until switches re-debounce.
- A switch held high through reset produces a rising event after debounce.

## Timing
- Read:
  - address presented with BUS_WE=0 at edge n;
  - read-enable and data are registered at edge n;
  - BUS_DATA is driven from edge n until the first edge at which the address no longer matches.
  - Read has no side effects.
- Write: BUS_DATA is sampled at the edge where BUS_WE=1 and the address matches; the register updates at that edge.
- SW change to STATE update:
  - 2 sync cycles, plus DEB_TICKS ticks of persistence, plus 1 cycle;
  - i.e. between 3+(DEB_TICKS-1)·TICK_CYCLES and 3+DEB_TICKS·TICK_CYCLES cycles.
- FLAG bit and SEND_INTERRUPT rise on the same edge, 1 cycle after the STATE flip.
- SEND_INTERRUPT falls on the edge after INTERRUPT_ACK is sampled high.
- Reset values: SEND_INTERRUPT 0, BUS_DATA Z, STATE 0, FLAG 0, MASK all ones, CTRL 0x03, all counters 0.

## Test plan
Bench parameters: N_SW=16, BASE_ADDR=E0, TICK_CYCLES=10, DEB_TICKS=3.

- Hold SW=16'h0001 steady.
  - Read E0 returns 0x01 and E1 returns 0x00 within 33 cycles.
  - FLAG E2=0x01; SEND_INTERRUPT=1.
  - Pulse ACK: SEND_INTERRUPT falls 1 cycle later.
  - Write 0x01 to E2: reads 0x00.
- Glitch SW[3] high for 15 cycles, then low.
  - STATE, FLAG and SEND_INTERRUPT unchanged.
- Write CTRL E6=0x02, set SW[9]=1, then release SW[9].
  - No flag on the rise.
  - Flag E3=0x02 on the fall; SEND_INTERRUPT=1.
- Write MASK E4=0x00, E5=0x00, then toggle SW[0] high.
  - FLAG E2 bit0=1; SEND_INTERRUPT stays 0.
- Hold ACK high in the exact cycle a new masked-in event occurs.
  - SEND_INTERRUPT remains 1.
  - A W1C coinciding with a new event on the same bit leaves that FLAG bit at 1.
- Assert RESETN low mid-debounce with SW=16'hFFFF.
  - SEND_INTERRUPT=0; all registers return to reset values.
  - After release: STATE reaches 0xFF/0xFF with FLAG set and SEND_INTERRUPT=1.
  - Reads of E7 and DF leave BUS_DATA at Z.
